// File: rtl/pe_result_accumulator.sv
// Receive-side accumulator for the adder-PE array: re-times issue valid/last to the PE output,
// sums one output pixel with bias and saturation, and queues finished pixels behind valid/ready.

module pe_result_accumulator_chk #(
   parameter int CNT_W     = 3,
   parameter int OUT_DEPTH = 4
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             push_req,
   input  logic             pop,
   input  logic [CNT_W-1:0] count
);

   // A finished pixel must never arrive at a full FIFO unless the head leaves in the same cycle.
   a_push_into_full: assert property (@(posedge clk) disable iff (!nrst)
      (push_req && (count == CNT_W'(OUT_DEPTH))) |-> pop);

   a_count_bound: assert property (@(posedge clk) disable iff (!nrst)
      count <= CNT_W'(OUT_DEPTH));

endmodule

module pe_result_accumulator #(
   parameter int PE_DATA_W  = 14,
   parameter int PE_LATENCY = 7,
   parameter int ACC_W      = 24,
   parameter int OUT_DEPTH  = 4
) (
   input  logic                        clk,
   input  logic                        nrst,
   input  logic                        issue_vld,
   input  logic                        issue_last,
   output logic                        issue_rdy,
   input  logic signed [ACC_W-1:0]     bias,
   input  logic signed [PE_DATA_W-1:0] pe_result,
   output logic signed [ACC_W-1:0]     out_data,
   output logic                        out_vld,
   input  logic                        out_rdy,
   output logic                        sat_flag
);

   localparam int PTR_W = $clog2(OUT_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int INF_W = $clog2(OUT_DEPTH + PE_LATENCY + 1) + 1;
   localparam logic [ACC_W-1:0] ACC_MIN_C = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [ACC_W-1:0] ACC_MAX_C = {1'b0, {(ACC_W-1){1'b1}}};

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Returns {neg_saturated, clamped_sum}.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                              input logic [PE_DATA_W-1:0] p);
      logic [ACC_W:0] wide;
      wide = {a[ACC_W-1], a} + {{(ACC_W+1-PE_DATA_W){p[PE_DATA_W-1]}}, p};
      if (wide[ACC_W] != wide[ACC_W-1]) begin
         if (wide[ACC_W]) begin
            sat_add = {1'b1, ACC_MIN_C};
         end else begin
            sat_add = {1'b0, ACC_MAX_C};
         end
      end else begin
         sat_add = {1'b0, wide[ACC_W-1:0]};
      end
   endfunction

   function automatic logic [INF_W-1:0] count_ones(input logic [PE_LATENCY-1:0] vec);
      count_ones = '0;
      for (int i = 0; i < PE_LATENCY; i++) begin
         count_ones = count_ones + INF_W'(vec[i]);
      end
   endfunction

   logic [PE_LATENCY-1:0] vld_sr_r, last_sr_r;
   logic [PE_LATENCY-1:0] vld_sr_nxt_s, last_sr_nxt_s;
   logic                  d_vld_s, d_last_s;
   state_t                state_r, state_nxt_s;
   logic [ACC_W-1:0]      acc_r, acc_nxt_s, base_s, push_data_s;
   logic [ACC_W:0]        sum_pack_s;
   logic                  push_req_s, sat_hit_s, sat_flag_r;

   logic [ACC_W-1:0]      mem_r [OUT_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
   logic [CNT_W-1:0]      count_r, count_nxt_s, remaining_s;
   logic                  pop_s, full_s, push_ok_s, head_from_push_s;
   logic [ACC_W-1:0]      head_nxt_s, out_data_r;
   logic                  out_vld_r, issue_rdy_r;
   logic [INF_W-1:0]      credit_use_s;

   // Beat k on the issue side lines up with pe_result exactly PE_LATENCY cycles later.
   always_comb begin
      vld_sr_nxt_s  = {vld_sr_r[PE_LATENCY-2:0], issue_vld};
      last_sr_nxt_s = {last_sr_r[PE_LATENCY-2:0], issue_vld && issue_last};
      d_vld_s       = vld_sr_r[PE_LATENCY-1];
      d_last_s      = last_sr_r[PE_LATENCY-1];
   end

   // Pixel sequencing: first beat adds bias, last beat pushes the finished sum.
   always_comb begin
      state_nxt_s = state_r;
      acc_nxt_s   = acc_r;
      push_req_s  = 1'b0;
      sat_hit_s   = 1'b0;
      base_s      = acc_r;
      if (state_r == IDLE) begin
         base_s = bias;
      end else begin
         base_s = acc_r;
      end
      sum_pack_s  = sat_add(base_s, pe_result);
      push_data_s = sum_pack_s[ACC_W-1:0];
      if (d_vld_s) begin
         sat_hit_s = sum_pack_s[ACC_W];
         case (state_r)
            IDLE: begin
               if (d_last_s) begin
                  push_req_s = 1'b1;
               end else begin
                  acc_nxt_s   = sum_pack_s[ACC_W-1:0];
                  state_nxt_s = RUN;
               end
            end
            RUN: begin
               if (d_last_s) begin
                  push_req_s  = 1'b1;
                  state_nxt_s = IDLE;
               end else begin
                  acc_nxt_s = sum_pack_s[ACC_W-1:0];
               end
            end
            default: begin
               state_nxt_s = IDLE;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Delay lines, accumulator, FSM state and sticky saturation flag.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         vld_sr_r   <= '0;
         last_sr_r  <= '0;
         state_r    <= IDLE;
         acc_r      <= '0;
         sat_flag_r <= 1'b0;
      end else begin
         vld_sr_r   <= vld_sr_nxt_s;
         last_sr_r  <= last_sr_nxt_s;
         state_r    <= state_nxt_s;
         acc_r      <= acc_nxt_s;
         sat_flag_r <= sat_flag_r || sat_hit_s;
      end
   end

   // FIFO bookkeeping; the output register is loaded with next cycle's head directly.
   always_comb begin
      pop_s            = out_vld_r && out_rdy;
      full_s           = (count_r == CNT_W'(OUT_DEPTH));
      push_ok_s        = push_req_s && (!full_s || pop_s);
      count_nxt_s      = count_r + CNT_W'(push_ok_s) - CNT_W'(pop_s);
      remaining_s      = count_r - CNT_W'(pop_s);
      rd_ptr_nxt_s     = rd_ptr_r + PTR_W'(pop_s);
      wr_ptr_nxt_s     = wr_ptr_r + PTR_W'(push_ok_s);
      head_from_push_s = push_ok_s && (remaining_s == '0);
      if (head_from_push_s) begin
         head_nxt_s = push_data_s;
      end else begin
         head_nxt_s = mem_r[rd_ptr_nxt_s];
      end
      // Credits cover results already queued plus every last beat still in the PE pipe.
      credit_use_s = INF_W'(count_nxt_s) + count_ones(last_sr_nxt_s);
   end

   // FIFO storage, pointers, registered head and registered credit.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < OUT_DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         count_r     <= '0;
         out_vld_r   <= 1'b0;
         out_data_r  <= '0;
         issue_rdy_r <= 1'b1;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
         end
         wr_ptr_r    <= wr_ptr_nxt_s;
         rd_ptr_r    <= rd_ptr_nxt_s;
         count_r     <= count_nxt_s;
         out_vld_r   <= (count_nxt_s != '0);
         out_data_r  <= head_nxt_s;
         issue_rdy_r <= (credit_use_s < INF_W'(OUT_DEPTH));
      end
   end

   assign out_data  = out_data_r;
   assign out_vld   = out_vld_r;
   assign issue_rdy = issue_rdy_r;
   assign sat_flag  = sat_flag_r;

   pe_result_accumulator_chk #(
      .CNT_W     (CNT_W),
      .OUT_DEPTH (OUT_DEPTH)
   ) u_chk (
      .clk      (clk),
      .nrst     (nrst),
      .push_req (push_req_s),
      .pop      (pop_s),
      .count    (count_r)
   );

endmodule

// File: tb/tb_pe_result_accumulator.sv
// Scoreboard bench for pe_result_accumulator: a PE emulator replays pe_result/bias PE_LATENCY
// cycles after issue, expected pixel sums are queued at issue and popped by an output monitor.

module tb_pe_result_accumulator;

   localparam int PE_DATA_W = 14;
   localparam int PE_LAT    = 7;
   localparam int ACC_W     = 16;
   localparam int OUT_DEPTH = 4;
   localparam int ACC_MIN   = -(1 << (ACC_W - 1));
   localparam int ACC_MAX   = (1 << (ACC_W - 1)) - 1;

   logic                        clk = 1'b0;
   logic                        nrst = 1'b0;
   logic                        issue_vld = 1'b0;
   logic                        issue_last = 1'b0;
   logic                        issue_rdy;
   logic signed [ACC_W-1:0]     bias;
   logic signed [PE_DATA_W-1:0] pe_result;
   logic signed [ACC_W-1:0]     out_data;
   logic                        out_vld;
   logic                        out_rdy;
   logic                        sat_flag;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int exp_q[$];
   int ring_cyc[16];
   int ring_pe[16];
   int ring_bias[16];
   bit ring_first[16];
   int pix_pe[8];
   bit rand_rdy_en = 1'b0;
   bit rdy_force   = 1'b0;
   bit sat_exp     = 1'b0;

   pe_result_accumulator #(
      .PE_DATA_W  (PE_DATA_W),
      .PE_LATENCY (PE_LAT),
      .ACC_W      (ACC_W),
      .OUT_DEPTH  (OUT_DEPTH)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .issue_vld  (issue_vld),
      .issue_last (issue_last),
      .issue_rdy  (issue_rdy),
      .bias       (bias),
      .pe_result  (pe_result),
      .out_data   (out_data),
      .out_vld    (out_vld),
      .out_rdy    (out_rdy),
      .sat_flag   (sat_flag)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic finish_test();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   endtask

   // PE emulator: presents the scheduled partial sum / bias, junk on every other cycle.
   always @(posedge clk) begin
      #1;
      if (ring_cyc[cyc % 16] == cyc) begin
         pe_result = PE_DATA_W'(ring_pe[cyc % 16]);
         bias      = ring_first[cyc % 16] ? ACC_W'(ring_bias[cyc % 16]) : ACC_W'($urandom);
      end else begin
         pe_result = PE_DATA_W'($urandom);
         bias      = ACC_W'($urandom);
      end
   end

   always @(posedge clk) begin
      #1;
      out_rdy = rand_rdy_en ? 1'($urandom_range(0, 1)) : rdy_force;
   end

   // Monitor: every accepted output must match the oldest expected pixel.
   always @(negedge clk) begin
      if (nrst && out_vld && out_rdy) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %0d, expected no output (cycle %0d)", out_data, cyc);
         end else begin
            check("out_data", out_data, exp_q.pop_front());
         end
      end
   end

   task automatic idle_cycle();
      @(posedge clk);
      #1;
      issue_last = 1'($urandom_range(0, 1));
   endtask

   task automatic drive_beat(input int pe, input int b, input bit first, input bit last);
      int slot;
      slot = (cyc + PE_LAT) % 16;
      ring_cyc[slot]   = cyc + PE_LAT;
      ring_pe[slot]    = pe;
      ring_bias[slot]  = b;
      ring_first[slot] = first;
      issue_vld  = 1'b1;
      issue_last = last;
      @(posedge clk);
      #1;
      issue_vld  = 1'b0;
      issue_last = 1'($urandom_range(0, 1));
   endtask

   // Issues one pixel from pix_pe[0..nb-1]; the expected result is the clamped plain sum.
   task automatic send_pixel(input int nb, input int b, input int gap_max);
      int sum;
      int guard;
      sum = b;
      for (int k = 0; k < nb; k++) begin
         if (k == nb - 1) begin
            guard = 0;
            while (!issue_rdy) begin
               idle_cycle();
               guard++;
               if (guard > 500) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL credit_timeout: issue_rdy stayed 0 for %0d cycles", guard);
                  finish_test();
               end
            end
            sum = sum + pix_pe[k];
            if (sum < ACC_MIN) sat_exp = 1'b1;
            exp_q.push_back(sum < ACC_MIN ? ACC_MIN : (sum > ACC_MAX ? ACC_MAX : sum));
            drive_beat(pix_pe[k], b, k == 0, 1'b1);
         end else begin
            sum = sum + pix_pe[k];
            drive_beat(pix_pe[k], b, k == 0, 1'b0);
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) idle_cycle();
         end
      end
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 3000) begin
         idle_cycle();
         guard++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
         finish_test();
      end
      repeat (3) idle_cycle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected test completion");
      n_fail++;
      finish_test();
   end

   initial begin
      int issued;
      int guard;
      for (int i = 0; i < 16; i++) ring_cyc[i] = -1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out_vld", out_vld, 0);
      check("reset_out_data", out_data, 0);
      check("reset_issue_rdy", issue_rdy, 1);
      check("reset_sat_flag", sat_flag, 0);
      @(posedge clk);
      #1;
      nrst = 1'b1;
      rdy_force = 1'b1;
      repeat (2) idle_cycle();

      // T1: single-beat pixel, exact latency
      pix_pe[0] = -3;
      send_pixel(1, 10, 0);
      repeat (7) @(negedge clk);
      check("t1_vld_before_latency", out_vld, 0);
      @(negedge clk);
      check("t1_vld_at_latency", out_vld, 1);
      check("t1_data", out_data, 7);
      @(negedge clk);
      check("t1_vld_after_pop", out_vld, 0);
      @(posedge clk);
      #1;
      wait_drain();

      // T2: three-beat pixel
      pix_pe[0] = -5; pix_pe[1] = -2; pix_pe[2] = -1;
      send_pixel(3, 0, 0);
      wait_drain();

      // T3: back-to-back two-beat pixels
      for (int p = 0; p < 4; p++) begin
         pix_pe[0] = -int'($urandom_range(0, 8191));
         pix_pe[1] = -int'($urandom_range(0, 8191));
         send_pixel(2, 100 * (p + 1), 0);
      end
      wait_drain();

      // T4: backpressure and credits
      rdy_force = 1'b0;
      repeat (2) idle_cycle();
      issued = 0;
      for (int c = 0; c < 20; c++) begin
         if (issue_rdy && issued < 6) begin
            pix_pe[0] = -int'($urandom_range(0, 8191));
            send_pixel(1, int'($urandom_range(0, 3000)), 0);
            issued++;
         end else begin
            idle_cycle();
         end
      end
      check("t4_credits_granted", issued, OUT_DEPTH);
      @(negedge clk);
      check("t4_rdy_low_when_full", issue_rdy, 0);
      check("t4_out_vld_held", out_vld, 1);
      rdy_force = 1'b1;
      guard = 0;
      while (!(out_vld && out_rdy) && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      check("t4_first_pop_seen", guard < 10, 1);
      check("t4_rdy_at_first_pop", issue_rdy, 0);
      @(negedge clk);
      check("t4_rdy_after_first_pop", issue_rdy, 1);
      @(posedge clk);
      #1;
      wait_drain();

      // T5: saturation at the accumulator minimum
      check("t5_sat_before", sat_flag, 0);
      pix_pe[0] = -100;
      send_pixel(1, -32760, 0);
      wait_drain();
      check("t5_sat_set", sat_flag, 1);
      pix_pe[0] = -1;
      send_pixel(1, 5, 0);
      wait_drain();
      check("t5_sat_sticky", sat_flag, 1);

      // T6: reset in the middle of a pixel
      drive_beat(-7, 50, 1'b1, 1'b0);
      drive_beat(-8, 50, 1'b0, 1'b0);
      idle_cycle();
      nrst = 1'b0;
      for (int i = 0; i < 16; i++) ring_cyc[i] = -1;
      sat_exp = 1'b0;
      @(negedge clk);
      check("t6_reset_out_vld", out_vld, 0);
      check("t6_reset_issue_rdy", issue_rdy, 1);
      check("t6_reset_sat_flag", sat_flag, 0);
      @(posedge clk);
      #1;
      nrst = 1'b1;
      repeat (12) idle_cycle();
      check("t6_no_stale_output", out_vld, 0);
      pix_pe[0] = 0;
      send_pixel(1, 1, 0);
      wait_drain();

      // Randomized traffic with random backpressure
      rand_rdy_en = 1'b1;
      for (int p = 0; p < 150; p++) begin
         int nb;
         int b;
         nb = int'($urandom_range(1, 4));
         case ($urandom_range(0, 7))
            0:       b = ACC_MIN + int'($urandom_range(0, 20000));
            1:       b = ACC_MAX - int'($urandom_range(0, 100));
            default: b = int'($urandom_range(0, 4000)) - 2000;
         endcase
         for (int k = 0; k < nb; k++) pix_pe[k] = -int'($urandom_range(0, 8191));
         send_pixel(nb, b, 2);
         repeat ($urandom_range(0, 2)) idle_cycle();
      end
      rand_rdy_en = 1'b0;
      rdy_force   = 1'b1;
      wait_drain();
      check("random_sat_flag", sat_flag, sat_exp);
      check("final_out_vld", out_vld, 0);
      check("final_issue_rdy", issue_rdy, 1);

      finish_test();
   end

endmodule
